// File: rtl/score_digit_renderer.sv
// Four-digit score overlay: serial binary-to-BCD conversion feeding a 24x24 glyph ROM pixel pipeline.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero glyphs (units glyph always shown).
module score_digit_renderer #(
    parameter int X0  = 16,
    parameter int Y0  = 8,
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] score,
    input  logic        score_valid,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        mem_q,
    output logic [3:0]  mem_digit,
    output logic [9:0]  mem_address,
    output logic        pixel_on,
    output logic        busy
);
    localparam int PITCH = 24 + GAP;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] load_q, load_d;
    logic [29:0] shreg_q, shreg_d;
    logic        pend_valid_q, pend_valid_d;
    logic [13:0] pend_score_q, pend_score_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  mem_digit_q, mem_digit_d;
    logic [9:0]  mem_address_q, mem_address_d;
    logic        infield1_q, infield1_d;
    logic        infield2_q;
    logic [13:0] score_sat;

    // One double-dabble iteration: bias every BCD nibble >= 5, then shift the whole register left.
    function automatic logic [29:0] dd_step(input logic [29:0] v_in);
        logic [29:0] v;
        v = v_in;
        for (int d = 0; d < 4; d++) begin
            if (v[14+4*d +: 4] >= 4'd5) begin
                v[14+4*d +: 4] = v[14+4*d +: 4] + 4'd3;
            end
        end
        return {v[28:0], 1'b0};
    endfunction

    assign score_sat = (score > 14'd9999) ? 14'd9999 : score;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_d       = load_q;
        shreg_d      = shreg_q;
        pend_valid_d = pend_valid_q;
        pend_score_d = pend_score_q;
        disp_d       = disp_q;
        case (state_q)
            S_IDLE: begin
                if (score_valid || pend_valid_q) begin
                    state_d      = S_CONVERT;
                    cnt_d        = 4'd0;
                    load_d       = score_valid ? score_sat : pend_score_q;
                    pend_valid_d = 1'b0;
                end
            end
            S_CONVERT: begin
                // First CONVERT cycle seeds the shift register; the next 14 cycles are the iterations.
                cnt_d   = cnt_q + 4'd1;
                shreg_d = (cnt_q == 4'd0) ? {16'd0, load_q} : dd_step(shreg_q);
                if (cnt_q == 4'd14) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = shreg_q[29:14];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && score_valid) begin
            pend_valid_d = 1'b1;
            pend_score_d = score_sat;
        end
    end

    // Glyph hit detection, one comparator pair per glyph; 11-bit compares avoid wrap at the screen edge.
    logic       in_y;
    logic [9:0] row10;
    logic [3:0] hit;
    logic [3:0] show;
    logic [9:0] col10 [4];

    assign in_y  = ({1'b0, pixel_y} >= 11'(Y0)) && ({1'b0, pixel_y} < 11'(Y0 + 24));
    assign row10 = pixel_y - 10'(Y0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
            localparam int LEFT = X0 + gi * PITCH;
            assign hit[gi]   = in_y && ({1'b0, pixel_x} >= 11'(LEFT))
                                    && ({1'b0, pixel_x} < 11'(LEFT + 24));
            assign col10[gi] = pixel_x - 10'(LEFT);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    assign show[0] = (disp_q[15:12] != 4'd0);
    assign show[1] = show[0] || (disp_q[11:8] != 4'd0);
    assign show[2] = show[1] || (disp_q[7:4] != 4'd0);
    assign show[3] = 1'b1;
`else
    assign show = 4'b1111;
`endif

    always_comb begin
        mem_digit_d   = 4'd0;
        mem_address_d = 10'd0;
        infield1_d    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
                mem_digit_d   = disp_q[15-4*i -: 4];
                mem_address_d = row10 * 10'd24 + col10[i];
                infield1_d    = show[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            load_q        <= 14'd0;
            shreg_q       <= 30'd0;
            pend_valid_q  <= 1'b0;
            pend_score_q  <= 14'd0;
            disp_q        <= 16'd0;
            mem_digit_q   <= 4'd0;
            mem_address_q <= 10'd0;
            infield1_q    <= 1'b0;
            infield2_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_q        <= load_d;
            shreg_q       <= shreg_d;
            pend_valid_q  <= pend_valid_d;
            pend_score_q  <= pend_score_d;
            disp_q        <= disp_d;
            mem_digit_q   <= mem_digit_d;
            mem_address_q <= mem_address_d;
            infield1_q    <= infield1_d;
            infield2_q    <= infield1_q;
        end
    end

    assign mem_digit   = mem_digit_q;
    assign mem_address = mem_address_q;
    // mem_q lines up with the second in-field stage because the ROM adds one cycle.
    assign pixel_on    = mem_q & infield2_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer with a one-cycle ROM model returning 1 for every valid address.
module tb_score_digit_renderer;
    localparam int X0 = 16;
    localparam int Y0 = 8;
    localparam int GAP = 4;
    localparam int PITCH = 24 + GAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] score = 14'd0;
    logic        score_valid = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        mem_q = 1'b0;
    logic [3:0]  mem_digit;
    logic [9:0]  mem_address;
    logic        pixel_on;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    score_digit_renderer #(.X0(X0), .Y0(Y0), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .mem_q(mem_q),
        .mem_digit(mem_digit), .mem_address(mem_address),
        .pixel_on(pixel_on), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= (mem_address <= 10'd575);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [13:0] v);
        score = v;
        score_valid = 1'b1;
        step();
        score_valid = 1'b0;
    endtask

    task automatic read_glyph(input int g, output logic [3:0] d);
        pixel_x = 10'(X0 + g * PITCH + 5);
        pixel_y = 10'(Y0 + 2);
        step();
        d = mem_digit;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_cnt += 4;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        if (pixel_on !== 1'b0) $display("FAIL reset_pixel_on: got %b want 0", pixel_on); else pass_cnt++;
        if (mem_digit !== 4'd0) $display("FAIL reset_mem_digit: got %0d want 0", mem_digit); else pass_cnt++;
        if (mem_address !== 10'd0) $display("FAIL reset_mem_address: got %0d want 0", mem_address); else pass_cnt++;
        step();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_convert_1234();
        int n;
        logic [3:0] d;
        logic [3:0] want [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        strobe(14'd1234);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== 16) $display("FAIL busy_cycles_1234: got %0d want 16", n); else pass_cnt++;
        for (int g = 0; g < 4; g++) begin
            read_glyph(g, d);
            total_cnt++;
            if (d !== want[g]) $display("FAIL digit_1234_g%0d: got %0d want %0d", g, d, want[g]);
            else pass_cnt++;
        end
        // Latency: park outside the field, then enter glyph 0 at (X0+5, Y0+2).
        pixel_x = 10'd0; pixel_y = 10'd0;
        step(); step();
        pixel_x = 10'(X0 + 5); pixel_y = 10'(Y0 + 2);
        step();
        total_cnt += 3;
        if (mem_digit !== 4'd1) $display("FAIL lat_mem_digit: got %0d want 1", mem_digit); else pass_cnt++;
        if (mem_address !== 10'd53) $display("FAIL lat_mem_address: got %0d want 53", mem_address); else pass_cnt++;
        if (pixel_on !== 1'b0) $display("FAIL lat_pixel_on_early: got %b want 0", pixel_on); else pass_cnt++;
        step();
        total_cnt++;
        if (pixel_on !== 1'b1) $display("FAIL lat_pixel_on_2cyc: got %b want 1", pixel_on); else pass_cnt++;
        $display("test_convert_1234 done busy_cycles=%0d", n);
    endtask

    task automatic test_saturate();
        logic [3:0] d;
        strobe(14'd12000);
        repeat (20) step();
        for (int g = 0; g < 4; g++) begin
            read_glyph(g, d);
            total_cnt++;
            if (d !== 4'd9) $display("FAIL sat_g%0d: got %0d want 9", g, d); else pass_cnt++;
        end
        $display("test_saturate done");
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [3] = '{4'd9, 4'd5, 4'd7};
        logic [3:0] last, d;
        int idx;
        bit bad;
        pixel_x = 10'(X0 + 3 * PITCH + 5);
        pixel_y = 10'(Y0 + 2);
        step();
        last = mem_digit;
        idx = 0; bad = 0;
        strobe(14'd5);
        step(); step();
        strobe(14'd77);
        for (int c = 0; c < 50; c++) begin
            if (mem_digit !== last) begin
                idx++;
                if (idx > 2 || mem_digit !== seq[idx]) bad = 1;
                last = mem_digit;
            end
            step();
        end
        total_cnt += 4;
        if (bad) $display("FAIL b2b_sequence: unexpected units value %0d at change %0d", last, idx); else pass_cnt++;
        if (idx !== 2) $display("FAIL b2b_changes: got %0d want 2", idx); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy); else pass_cnt++;
        read_glyph(2, d);
        if (d !== 4'd7) $display("FAIL b2b_tens: got %0d want 7", d); else pass_cnt++;
        $display("test_back_to_back done changes=%0d", idx);
    endtask

    task automatic test_gap_and_bounds();
        pixel_x = 10'(X0 + 25); pixel_y = 10'(Y0 + 2);
        step();
        total_cnt += 2;
        if (mem_address !== 10'd0) $display("FAIL gap_address: got %0d want 0", mem_address); else pass_cnt++;
        if (mem_digit !== 4'd0) $display("FAIL gap_digit: got %0d want 0", mem_digit); else pass_cnt++;
        pixel_x = 10'(X0 + 5); pixel_y = 10'(Y0 + 24);
        step();
        total_cnt += 2;
        if (pixel_on !== 1'b0) $display("FAIL gap_pixel_on: got %b want 0", pixel_on); else pass_cnt++;
        if (mem_address !== 10'd0) $display("FAIL below_address: got %0d want 0", mem_address); else pass_cnt++;
        pixel_x = 10'(X0 + 3 * PITCH + 23); pixel_y = 10'(Y0 + 23);
        step();
        total_cnt += 2;
        if (pixel_on !== 1'b0) $display("FAIL below_pixel_on: got %b want 0", pixel_on); else pass_cnt++;
        if (mem_address !== 10'd575) $display("FAIL corner_address: got %0d want 575", mem_address); else pass_cnt++;
        pixel_x = 10'(X0 + 3 * PITCH + 24);
        step();
        total_cnt++;
        if (mem_address !== 10'd0) $display("FAIL right_edge_address: got %0d want 0", mem_address); else pass_cnt++;
        $display("test_gap_and_bounds done");
    endtask

    task automatic test_leading_zero();
        logic [3:0] d;
        logic exp_on;
`ifdef LEADING_ZERO_BLANK_EN
        exp_on = 1'b0;
`else
        exp_on = 1'b1;
`endif
        strobe(14'd42);
        repeat (20) step();
        for (int g = 0; g < 2; g++) begin
            read_glyph(g, d);
            step();
            total_cnt += 2;
            if (d !== 4'd0) $display("FAIL lz_digit_g%0d: got %0d want 0", g, d); else pass_cnt++;
            if (pixel_on !== exp_on) $display("FAIL lz_pixel_on_g%0d: got %b want %b", g, pixel_on, exp_on);
            else pass_cnt++;
        end
        read_glyph(2, d);
        step();
        total_cnt += 2;
        if (d !== 4'd4) $display("FAIL lz_tens: got %0d want 4", d); else pass_cnt++;
        if (pixel_on !== 1'b1) $display("FAIL lz_tens_on: got %b want 1", pixel_on); else pass_cnt++;
        read_glyph(3, d);
        total_cnt++;
        if (d !== 4'd2) $display("FAIL lz_units: got %0d want 2", d); else pass_cnt++;
        $display("test_leading_zero done");
    endtask

    task automatic test_reset_mid_convert();
        logic [3:0] d;
        pixel_x = 10'(X0 + 3 * PITCH + 5);
        pixel_y = 10'(Y0 + 2);
        strobe(14'd1234);
        repeat (5) step();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt += 4;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
        if (pixel_on !== 1'b0) $display("FAIL midrst_pixel_on: got %b want 0", pixel_on); else pass_cnt++;
        if (mem_digit !== 4'd0) $display("FAIL midrst_mem_digit: got %0d want 0", mem_digit); else pass_cnt++;
        if (mem_address !== 10'd0) $display("FAIL midrst_mem_address: got %0d want 0", mem_address); else pass_cnt++;
        step();
        rst_n = 1'b1;
        repeat (30) step();
        for (int g = 0; g < 4; g++) begin
            read_glyph(g, d);
            total_cnt++;
            if (d !== 4'd0) $display("FAIL midrst_digit_g%0d: got %0d want 0", g, d); else pass_cnt++;
        end
        $display("test_reset_mid_convert done");
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_saturate();
        test_back_to_back();
        test_gap_and_bounds();
        test_leading_zero();
        test_reset_mid_convert();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/score_digit_renderer.md
SCORE_DIGIT_RENDERER -- requirements
Module: score_digit_renderer

Interface
REQ-001 Parameter X0, 16: left pixel column of the score field.
REQ-002 Parameter Y0, 8: top pixel row of the score field.
REQ-003 Parameter GAP, 4: blank columns between adjacent digit glyphs.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 score  input  14  binary score value.
REQ-007 score_valid  input  1  one-cycle strobe that loads score.
REQ-008 pixel_x  input  10  current beam column.
REQ-009 pixel_y  input  10  current beam row.
REQ-010 mem_q  input  1  glyph bit returned by the digit ROM one cycle after mem_digit/mem_address.
REQ-011 mem_digit  output  4  glyph select to the digit ROM, registered.
REQ-012 mem_address  output  10  glyph bit index to the digit ROM, registered; row*24+col.
REQ-013 pixel_on  output  1  score pixel lit.
REQ-014 busy  output  1  conversion in progress.

Function
REQ-015 Field: four 24x24 glyphs, thousands leftmost; glyph i (0..3) at columns X0+i*(24+GAP) .. +23, rows Y0..Y0+23.
REQ-016 Scores above 9999 SHALL saturate to 9999 at load.
REQ-017 Binary-to-BCD SHALL use sequential shift-add-3 over exactly 14 iterations.
- FSM: IDLE -> CONVERT on score_valid; CONVERT -> DONE after the 14th shift; DONE -> IDLE after one cycle.
- busy high in CONVERT and DONE.
REQ-018 Displayed digit register SHALL update atomically on DONE only; partial BCD is never displayed.
REQ-019 score_valid while busy SHALL be held as one pending request (latest value wins), started on the cycle after DONE.
REQ-020 score_valid in the same cycle as DONE SHALL become the pending request and start on the next cycle.
REQ-021 Pixel pipeline, coordinates sampled at edge k:
- after edge k, mem_digit = displayed digit of the covering glyph and mem_address = (pixel_y-Y0)*24+(pixel_x-glyph_left);
- in-field flag registered twice;
- pixel_on = mem_q AND in-field flag (stage 2), i.e. two-cycle latency from coordinates.
REQ-022 Outside every glyph (including gap columns and rows outside the field), mem_digit and mem_address SHALL be 0 and in-field SHALL be 0.
REQ-023 mem_address SHALL never exceed 575.
REQ-024 The pixel pipeline SHALL run every cycle, independent of conversion state.

Reset
REQ-025 On rst_n low, asynchronously: FSM IDLE, busy 0, pending cleared, displayed digits 0000, mem_digit 0, mem_address 0, in-field flags 0, pixel_on 0.
REQ-026 Reset during CONVERT SHALL abort the conversion; no digit update occurs.
REQ-027 After rst_n release, the first score_valid SHALL be accepted on the first rising edge.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN:
- defined: leading zero glyphs are blanked (in-field forced 0); the units glyph is always shown; score 0 shows a single "0";
- undefined: all four glyphs always shown, including leading zeros.

Verification
REQ-029 Reset, then score=1234 strobe -> busy high 16 cycles; digits 1,2,3,4; pixel at (X0+5,Y0+2) gives mem_digit=1, mem_address=53 one cycle later.
REQ-030 score=12000 -> displayed 9999.
REQ-031 score=5 then score=77 strobed during busy -> 5 displayed, then 77 without a further strobe; no intermediate value visible.
REQ-032 Sweep pixel_x across a gap column (X0+25) -> mem_address 0, pixel_on 0; ROM model with mem_q=1 everywhere -> pixel_on high exactly two cycles after in-glyph coordinates.
REQ-033 score=42 with LEADING_ZERO_BLANK_EN -> glyphs 0,1 never lit; without the macro -> "0042" rendered.
REQ-034 Assert rst_n low mid-CONVERT -> outputs zero immediately; digits remain 0000 after release.
